// File: rtl/clahe_pkg.sv
// rtl/clahe_pkg.sv - shared CLAHE constants, widths and CDF builder state encoding
package clahe_pkg;

  localparam int BINS   = 256;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int BLK_W  = 5;
  localparam int ACC_W  = 24;

  localparam logic [ADDR_W-1:0] LAST_BIN = ADDR_W'(BINS - 1);
  localparam logic [DATA_W-1:0] SAT_VAL  = 16'hFFFF;

  typedef enum logic [2:0] {
    IDLE,
    SCAN_EXCESS,
    WAIT,
    SCAN_CDF,
    DONE
  } state_t;

endpackage

// File: rtl/clip_sat_acc.sv
// rtl/clip_sat_acc.sv - clip to limit, add redistributed share, saturating CDF accumulator
module clip_sat_acc
  import clahe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clear_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] h_i,
  input  logic [DATA_W-1:0] clip_i,
  input  logic [DATA_W-1:0] per_i,
  input  logic              bump_i,
  output logic [DATA_W-1:0] sat_o
);

  logic [ACC_W-1:0]  acc_q, acc_d, sum;
  logic [DATA_W-1:0] clipped;

  // sat_o reflects the value the accumulator takes this cycle, so the caller registers it alongside
  always_comb begin
    clipped = h_i;
    if (clip_i != '0 && h_i > clip_i) clipped = clip_i;
    sum   = acc_q + ACC_W'(clipped) + ACC_W'(per_i) + ACC_W'(bump_i);
    sat_o = (sum > ACC_W'(SAT_VAL)) ? SAT_VAL : sum[DATA_W-1:0];
    acc_d = acc_q;
    if (clear_i)   acc_d = '0;
    else if (en_i) acc_d = sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) acc_q <= '0;
    else     acc_q <= acc_d;
  end

endmodule

// File: rtl/cdf_clip_builder.sv
// rtl/cdf_clip_builder.sv - two-pass clip-limited CDF builder for one 256-bin tile histogram
module cdf_clip_builder
  import clahe_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [BLK_W-1:0]  src_block,
  input  logic [BLK_W-1:0]  dst_block,
  input  logic [DATA_W-1:0] clip_limit,
  output logic              busy,
  output logic              done,
  output logic [BLK_W-1:0]  rd_block,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [BLK_W-1:0]  wr_block,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic              wr_en
);

  state_t            state_q, state_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [BLK_W-1:0]  src_q, dst_q;
  logic [DATA_W-1:0] clip_q;
  logic [ACC_W-1:0]  excess_q;
  logic              vld_q, phase_q;
  logic [ADDR_W-1:0] bin_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic              issue, accept, cdf_en;
  logic [DATA_W-1:0] sat;

  assign accept = (state_q == IDLE) && start;
  assign cdf_en = vld_q && phase_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    issue   = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = SCAN_EXCESS;
        cnt_d   = '0;
      end
      SCAN_EXCESS: begin
        issue = 1'b1;
        if (cnt_q[ADDR_W-1:0] == LAST_BIN) begin
          state_d = WAIT;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WAIT: begin
        state_d = SCAN_CDF;
        cnt_d   = '0;
      end
      SCAN_CDF: begin
        // cnt_q[ADDR_W] marks all reads issued; the state then waits for the last write to drain
        if (!cnt_q[ADDR_W]) begin
          issue = 1'b1;
          cnt_d = cnt_q + 1'b1;
        end
        if (wr_en_q && wr_addr_q == LAST_BIN) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      src_q     <= '0;
      dst_q     <= '0;
      clip_q    <= '0;
      excess_q  <= '0;
      vld_q     <= 1'b0;
      phase_q   <= 1'b0;
      bin_q     <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      vld_q   <= issue;
      phase_q <= (state_q == SCAN_CDF);
      bin_q   <= cnt_q[ADDR_W-1:0];
      wr_en_q <= cdf_en;
      if (accept) begin
        src_q    <= src_block;
        dst_q    <= dst_block;
        clip_q   <= clip_limit;
        excess_q <= '0;
      end else if (vld_q && !phase_q && clip_q != '0 && rd_data > clip_q) begin
        excess_q <= excess_q + ACC_W'(rd_data - clip_q);
      end
      if (cdf_en) begin
        wr_addr_q <= bin_q;
        wr_data_q <= sat;
      end
    end
  end

  clip_sat_acc u_acc (
    .clk     (clk),
    .rst     (rst),
    .clear_i (accept),
    .en_i    (cdf_en),
    .h_i     (rd_data),
    .clip_i  (clip_q),
    .per_i   (excess_q[ACC_W-1:ADDR_W]),
    .bump_i  (bin_q < excess_q[ADDR_W-1:0]),
    .sat_o   (sat)
  );

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign rd_block = src_q;
  assign rd_addr  = cnt_q[ADDR_W-1:0];
  assign wr_block = dst_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign wr_en    = wr_en_q;

endmodule

// File: doc/cdf_clip_builder.md
# cdf_clip_builder

Converts one tile's 256-bin histogram into a clip-limited cumulative distribution (CDF) for CLAHE. It reads the histogram from the histogram RAM bank array through the port-A read path. It computes clipped excess and redistributes it uniformly, then writes the CDF back through the port-B write path. It sits between histogram accumulation and interpolation and runs once per tile per frame.

## Interface
Parameters:
- BINS, 256, histogram bins per tile; address width 8.
- DATA_W, 16, bin / CDF word width.
- BLK_W, 5, bank (tile) select width; 32 banks.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; accepted only when busy=0.
- src_block  in  5  bank holding the histogram; sampled on acceptance.
- dst_block  in  5  bank receiving the CDF; sampled on acceptance; may equal src_block.
- clip_limit  in  16  per-bin clip level; sampled on acceptance; 0 = clipping disabled.
- busy  out  1  high from the acceptance edge until done.
- done  out  1  one-cycle pulse after the last write.
- rd_block  out  5  port-A read bank select.
- rd_addr  out  8  port-A address.
- rd_data  in  16  port-A read data; valid exactly 1 cycle after rd_addr/rd_block.
- wr_block  out  5  port-B write bank select.
- wr_addr  out  8  port-B address.
- wr_data  out  16  CDF value.
- wr_en  out  1  qualifies wr_block. Integration gates the port-B bank decoder with it.

## Operation
- States: IDLE, SCAN_EXCESS, WAIT, SCAN_CDF, DONE.
- IDLE: start=1 latches src/dst/clip, clears accumulators, goes to SCAN_EXCESS, sets busy.
- SCAN_EXCESS: rd_addr counts 0..255. For each returned h: excess += (h > clip) ? h - clip : 0. Excess is a 24-bit unsigned value and cannot overflow.
- WAIT: one cycle to absorb data for bin 255. Then per = excess[23:8] and resid = excess[7:0].
- SCAN_CDF: rd_addr counts 0..255 again. For bin i: c = min(h, clip) + per + (i < resid ? 1 : 0). acc += c, with acc 24 bits. wr_data = (acc > 16'hFFFF) ? 16'hFFFF : acc[15:0]. wr_addr = i. wr_block = dst.
- Clip disabled (clip_limit=0): min() passes h through and excess stays 0.
- DONE: one cycle with done=1, then IDLE.
- start while busy is ignored and not queued.
- In-place operation (src=dst) is safe because bin i is read before CDF[i] is written.
- rd_data outside the scan data windows is ignored.

## Timing
- Reset values: busy=0, done=0, wr_en=0, rd_block=0, rd_addr=0, wr_block=0, wr_addr=0, wr_data=0. State goes to IDLE and accumulators to 0.
- rst asserted mid-run aborts immediately with no further wr_en. A partially written CDF is left as is.
- Cycle 0 is the first cycle after the acceptance edge.
- Cycles 0–255: SCAN_EXCESS reads; data arrives in cycles 1–256.
- Cycle 256: WAIT.
- Cycles 257–512: SCAN_CDF reads; data arrives in 258–513.
- wr_en is registered and high in cycles 259–514 for bins 0–255, one bin per cycle with no gaps.
- done=1 in cycle 515; busy falls in cycle 516.
- Total: 516 cycles from start acceptance to busy low. A new start can be accepted in cycle 516.
- rd_block is held at src for the whole run. wr_block/wr_addr/wr_data are only meaningful when wr_en=1.

## Structure
- Shared package `clahe_pkg` holds BINS, DATA_W, BLK_W, the state enum, and the saturation constant 16'hFFFF.
- One natural sub-module: `clip_sat_acc`. It holds the clip/min, the redistribution add and the saturating 24-bit accumulator, so it can be reused by the interpolation-side LUT builder.
- FSM, address counter and latency pipeline register stay in the top module.

## Test plan
- Uniform: all bins 4, clip 10 → excess 0; CDF[i] = 4(i+1), CDF[255] = 1024; done in cycle 515.
- Spike, even excess: bin0=4096, others 0, clip 256 → excess 3840, per 15, resid 0; CDF[0]=271, CDF[i]=271+15i, CDF[255]=4096.
- Residual: bin0=300, others 0, clip 256 → per 0, resid 44; CDF[0]=257, CDF[43]=300, CDF[44..255]=300.
- Saturation: all bins 65535, clip 0 → every wr_data = 16'hFFFF; exactly 256 wr_en pulses to dst_block.
- start pulsed again in cycle 100 with different src/dst → ignored; run completes with the original banks and a single done.
- rst asserted in cycle 300 → all outputs 0 next cycle, no wr_en afterwards. A fresh start then completes correctly with src=dst.
